// File: rtl/regfile_hilo.sv
// Architectural GPR file (r0 reads as zero) plus HI/LO, written from the packed WB bus.
// Define RF_BYPASS_EN to make a same-cycle write visible on the read ports.
module regfile_hilo (
    input  logic         clk,
    input  logic         rst,
    input  logic [103:0] wb_to_rf_bus,
    input  logic [4:0]   raddr1,
    output logic [31:0]  rdata1,
    input  logic [4:0]   raddr2,
    output logic [31:0]  rdata2,
    output logic [31:0]  hi_rdata,
    output logic [31:0]  lo_rdata,
    output logic [31:0]  rf_commit_cnt
);
    localparam int WB_TO_RF_WD = 38;

    // No handshake: the bus is valid every cycle and an all-zero bus is a bubble.
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        gpr_wr;

    assign {hi_we, lo_we, hi_wdata, lo_wdata} = wb_to_rf_bus[WB_TO_RF_WD+65:WB_TO_RF_WD];
    assign {rf_we, rf_waddr, rf_wdata}        = wb_to_rf_bus[WB_TO_RF_WD-1:0];
    assign gpr_wr = rf_we && (rf_waddr != 5'd0);

    logic [31:0] regs [32];
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] commit_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            hi_q         <= '0;
            lo_q         <= '0;
            commit_cnt_q <= '0;
        end else begin
            if (gpr_wr) begin
                regs[rf_waddr] <= rf_wdata;
                commit_cnt_q   <= commit_cnt_q + 32'd1;
            end
            if (hi_we) begin
                hi_q <= hi_wdata;
            end
            if (lo_we) begin
                lo_q <= lo_wdata;
            end
        end
    end

    assign rf_commit_cnt = commit_cnt_q;

    always_comb begin
        rdata1   = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
        rdata2   = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
        hi_rdata = hi_q;
        lo_rdata = lo_q;
`ifdef RF_BYPASS_EN
        // Forwarding ignores rst so no combinational path exists from reset to outputs.
        if (gpr_wr && (rf_waddr == raddr1)) begin
            rdata1 = rf_wdata;
        end
        if (gpr_wr && (rf_waddr == raddr2)) begin
            rdata2 = rf_wdata;
        end
        if (hi_we) begin
            hi_rdata = hi_wdata;
        end
        if (lo_we) begin
            lo_rdata = lo_wdata;
        end
`endif
    end
endmodule

// File: tb/tb_regfile_hilo.sv
// Directed bench for regfile_hilo: driver pushes expected read-port values, a negedge monitor compares.
// Expectations for same-cycle reads follow the RF_BYPASS_EN build setting.
module tb_regfile_hilo;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cnt;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [103:0] wb_to_rf_bus = '0;
    logic [4:0]   raddr1 = '0;
    logic [4:0]   raddr2 = '0;
    logic [31:0]  rdata1;
    logic [31:0]  rdata2;
    logic [31:0]  hi_rdata;
    logic [31:0]  lo_rdata;
    logic [31:0]  rf_commit_cnt;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int passed = 0;
    int fails  = 0;

    regfile_hilo dut (
        .clk          (clk),
        .rst          (rst),
        .wb_to_rf_bus (wb_to_rf_bus),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .raddr2       (raddr2),
        .rdata2       (rdata2),
        .hi_rdata     (hi_rdata),
        .lo_rdata     (lo_rdata),
        .rf_commit_cnt(rf_commit_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [103:0] mk_bus(input logic hwe, input logic lwe,
                                            input logic [31:0] hd, input logic [31:0] ld,
                                            input logic we, input logic [4:0] wa,
                                            input logic [31:0] wd);
        return {hwe, lwe, hd, ld, we, wa, wd};
    endfunction

    // driver: apply one cycle of inputs and push what the read ports must show in it
    task automatic drive(input logic r, input logic [103:0] bus,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [7:0] tag,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input logic [31:0] eh, input logic [31:0] el, input logic [31:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        wb_to_rf_bus = bus;
        raddr1       = a1;
        raddr2       = a2;
        e.tag = tag; e.r1 = e1; e.r2 = e2; e.hi = eh; e.lo = el; e.cnt = ec;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [7:0] tag,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            fails++;
            $display("FAIL %s tag=%0d actual=%08h required=%08h", name, tag, act, req);
        end
    endtask

    // monitor / scoreboard: read ports are always presented, one expectation per cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("rdata1", e.tag, rdata1, e.r1);
            cmp("rdata2", e.tag, rdata2, e.r2);
            cmp("hi_rdata", e.tag, hi_rdata, e.hi);
            cmp("lo_rdata", e.tag, lo_rdata, e.lo);
            cmp("rf_commit_cnt", e.tag, rf_commit_cnt, e.cnt);
        end
    end

    logic [103:0] idle;

    initial begin
        idle = '0;
        rst  = 1'b1;
        repeat (2) @(posedge clk);

        // reset state on every address of both ports
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, idle, 5'(a), 5'(31 - a), 8'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        end

        // r5 write, same-cycle then next-cycle read
        drive(1'b0, mk_bus(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF), 5'd5, 5'd0, 8'd1,
              BYP ? 32'hDEADBEEF : 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        drive(1'b0, idle, 5'd5, 5'd5, 8'd2, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0, 32'd0, 32'd1);

        // r0 write is discarded and not counted
        drive(1'b0, mk_bus(0, 0, 0, 0, 1, 5'd0, 32'h12345678), 5'd0, 5'd0, 8'd3,
              32'd0, 32'd0, 32'd0, 32'd0, 32'd1);
        drive(1'b0, idle, 5'd0, 5'd0, 8'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1);

        // HI, LO and r31 in one cycle, then LO alone
        drive(1'b0, mk_bus(1, 1, 32'h1, 32'h2, 1, 5'd31, 32'hA5A5A5A5), 5'd31, 5'd5, 8'd5,
              BYP ? 32'hA5A5A5A5 : 32'd0, 32'hDEADBEEF,
              BYP ? 32'd1 : 32'd0, BYP ? 32'd2 : 32'd0, 32'd1);
        drive(1'b0, mk_bus(0, 1, 32'h0, 32'h3, 0, 5'd0, 32'd0), 5'd31, 5'd31, 8'd6,
              32'hA5A5A5A5, 32'hA5A5A5A5, 32'd1, BYP ? 32'd3 : 32'd2, 32'd2);
        drive(1'b0, idle, 5'd31, 5'd5, 8'd7, 32'hA5A5A5A5, 32'hDEADBEEF, 32'd1, 32'd3, 32'd2);

        // reset wins over a same-cycle write
        drive(1'b1, mk_bus(0, 0, 0, 0, 1, 5'd7, 32'h55), 5'd7, 5'd31, 8'd8,
              BYP ? 32'h55 : 32'd0, 32'hA5A5A5A5, 32'd1, 32'd3, 32'd2);
        drive(1'b0, idle, 5'd7, 5'd31, 8'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // GPR writes alongside single HI or LO writes
        drive(1'b0, mk_bus(1, 0, 32'h77, 32'h0, 1, 5'd10, 32'h13579BDF), 5'd10, 5'd10, 8'd10,
              BYP ? 32'h13579BDF : 32'd0, BYP ? 32'h13579BDF : 32'd0,
              BYP ? 32'h77 : 32'd0, 32'd0, 32'd0);
        drive(1'b0, mk_bus(0, 1, 32'h0, 32'h88, 1, 5'd2, 32'h0BADF00D), 5'd10, 5'd2, 8'd11,
              32'h13579BDF, BYP ? 32'h0BADF00D : 32'd0, 32'h77, BYP ? 32'h88 : 32'd0, 32'd1);
        drive(1'b0, idle, 5'd2, 5'd10, 8'd12, 32'h0BADF00D, 32'h13579BDF, 32'h77, 32'h88, 32'd2);

        // rf_we=0 with nonzero address is a no-op
        drive(1'b0, mk_bus(0, 0, 0, 0, 0, 5'd3, 32'hFFFF), 5'd3, 5'd2, 8'd13,
              32'd0, 32'h0BADF00D, 32'h77, 32'h88, 32'd2);
        drive(1'b0, idle, 5'd3, 5'd2, 8'd14, 32'd0, 32'h0BADF00D, 32'h77, 32'h88, 32'd2);

        // counter wrap: preload all-ones, then one r1 write
        drive(1'b0, mk_bus(0, 0, 0, 0, 1, 5'd1, 32'h1), 5'd1, 5'd0, 8'd15,
              BYP ? 32'h1 : 32'd0, 32'd0, 32'h77, 32'h88, 32'hFFFFFFFF);
        dut.commit_cnt_q = 32'hFFFFFFFF;
        drive(1'b0, idle, 5'd1, 5'd2, 8'd16, 32'h1, 32'h0BADF00D, 32'h77, 32'h88, 32'd0);

        begin
            int budget;
            budget = 0;
            while (exp_q.size() > 0 && budget < 10) begin
                @(posedge clk);
                budget++;
            end
            if (exp_q.size() > 0) begin
                checks++;
                fails++;
                $display("FAIL drain actual=%0d pending required=0", exp_q.size());
            end
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
